// File: rtl/fsub_pipe.sv
// Single-precision subtractor y = x1 - x2, three registered stages (align / add-sub / normalize).
// Latency 3 cycles at one result per cycle; all stages stall together while a result waits on out_ready.
// Optional overflow/underflow flag port `exc` when FSUB_FLAGS_EN is defined.
module fsub_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
`ifdef FSUB_FLAGS_EN
   ,
   output logic [1:0]  exc
`endif
);

   // Pipeline control: every stage moves when the output slot is empty or being drained.
   logic advance;
   logic v1_q, v2_q, v3_q;

   assign advance   = ~v3_q | out_ready;
   assign in_ready  = advance;
   // A result never leaves during a reset cycle; it is about to be discarded.
   assign out_valid = v3_q & ~rst;

   // ------------------------------------------------------------------
   // S1: unpack, effective-sign, magnitude compare, swap, align
   // ------------------------------------------------------------------
   logic        s2_eff;
   logic        sub_op;
   logic        x1_big;
   logic        sign_sup_d1;
   logic [7:0]  e_sup_d1, e_inf_d1, exp_diff;
   logic [4:0]  shamt;
   logic [25:0] m_sup_d1, m_inf_d1, m_inf_sh;
   logic        byp_d1;
   logic [31:0] bypy_d1;

   // Swap so the superior operand is first, then shift the inferior mantissa into place.
   always_comb begin
      s2_eff = ~x2[31];
      sub_op = x1[31] ^ s2_eff;
      // {exp, man} packed ordering gives exponent-then-mantissa magnitude compare.
      x1_big = x1[30:0] >= x2[30:0];
      if (x1_big) begin
         sign_sup_d1 = x1[31];
         e_sup_d1    = x1[30:23];
         e_inf_d1    = x2[30:23];
         m_sup_d1    = {1'b1, x1[22:0], 2'b00};
         m_inf_d1    = {1'b1, x2[22:0], 2'b00};
      end else begin
         sign_sup_d1 = s2_eff;
         e_sup_d1    = x2[30:23];
         e_inf_d1    = x1[30:23];
         m_sup_d1    = {1'b1, x2[22:0], 2'b00};
         m_inf_d1    = {1'b1, x1[22:0], 2'b00};
      end
      exp_diff = e_sup_d1 - e_inf_d1;
      shamt    = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
      m_inf_sh = m_inf_d1 >> shamt;

      // Zero operands and exact cancellation skip the arithmetic entirely.
      byp_d1  = 1'b0;
      bypy_d1 = 32'h0;
      if (x1[30:23] == 8'h00) begin
         byp_d1  = 1'b1;
         bypy_d1 = {s2_eff, x2[30:0]};
      end else if (x2[30:23] == 8'h00) begin
         byp_d1  = 1'b1;
         bypy_d1 = x1;
      end else if (sub_op && (x1[30:0] == x2[30:0])) begin
         byp_d1  = 1'b1;
         bypy_d1 = {x1[31] & s2_eff, 31'h0};
      end
   end

   logic        sign1_q, sub1_q, byp1_q;
   logic [7:0]  exp1_q;
   logic [25:0] msup1_q, minf1_q;
   logic [31:0] bypy1_q;

   // S1 register: loads whenever the pipe advances.
   always_ff @(posedge clk) begin
      if (advance) begin
         sign1_q <= sign_sup_d1;
         sub1_q  <= sub_op;
         byp1_q  <= byp_d1;
         exp1_q  <= e_sup_d1;
         msup1_q <= m_sup_d1;
         minf1_q <= m_inf_sh;
         bypy1_q <= bypy_d1;
      end
   end

   // ------------------------------------------------------------------
   // S2: magnitude add or subtract (superior >= inferior, so no sign flip)
   // ------------------------------------------------------------------
   logic [26:0] sum_d2;

   // 27-bit sum keeps the carry out of a same-sign add.
   always_comb begin
      if (sub1_q) sum_d2 = {1'b0, msup1_q} - {1'b0, minf1_q};
      else        sum_d2 = {1'b0, msup1_q} + {1'b0, minf1_q};
   end

   logic        sign2_q, byp2_q;
   logic [7:0]  exp2_q;
   logic [26:0] sum2_q;
   logic [31:0] bypy2_q;

   // S2 register.
   always_ff @(posedge clk) begin
      if (advance) begin
         sign2_q <= sign1_q;
         byp2_q  <= byp1_q;
         exp2_q  <= exp1_q;
         sum2_q  <= sum_d2;
         bypy2_q <= bypy1_q;
      end
   end

   // ------------------------------------------------------------------
   // S3: leading-one detect, normalize, range check, pack (truncating)
   // ------------------------------------------------------------------
   logic [4:0]        lead_pos, lz;
   logic [24:0]       norm;
   logic signed [9:0] exp_r;
   logic [22:0]       man_r;
   logic              ovf, unf;
   logic [31:0]       y_d;
   logic [1:0]        flags_d;

   // Normalize the sum and choose between packed, saturated, flushed or bypass result.
   always_comb begin
      lead_pos = 5'd0;
      for (int i = 0; i < 26; i++) begin
         if (sum2_q[i]) lead_pos = 5'(i);
      end
      lz   = 5'd25 - lead_pos;
      norm = sum2_q[24:0] << lz;
      if (sum2_q[26]) begin
         exp_r = $signed({2'b00, exp2_q}) + 10'sd1;
         man_r = sum2_q[25:3];
      end else begin
         exp_r = $signed({2'b00, exp2_q}) - $signed({5'b00000, lz});
         man_r = 23'(norm >> 2);
      end
      ovf = exp_r >= 10'sd255;
      unf = exp_r <= 10'sd0;

      flags_d = 2'b00;
      if (byp2_q) begin
         y_d = bypy2_q;
      end else if (ovf) begin
         y_d     = {sign2_q, 8'hFF, 23'h0};
         flags_d = 2'b10;
      end else if (unf) begin
         y_d     = {sign2_q, 8'h00, 23'h0};
         flags_d = 2'b01;
      end else begin
         y_d = {sign2_q, exp_r[7:0], man_r};
      end
   end

   logic [31:0] y_q;
`ifdef FSUB_FLAGS_EN
   logic [1:0]  exc_q;
`endif

   // Valid bits and output register; the output only changes when a new result arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         y_q  <= 32'h0;
`ifdef FSUB_FLAGS_EN
         exc_q <= 2'b00;
`endif
      end else if (advance) begin
         v1_q <= in_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (v2_q) begin
            y_q <= y_d;
`ifdef FSUB_FLAGS_EN
            exc_q <= flags_d;
`endif
         end
      end
   end

   assign y = y_q;
`ifdef FSUB_FLAGS_EN
   assign exc = exc_q;
`endif

endmodule

// File: tb/tb_fsub_pipe.sv
// Self-checking bench for fsub_pipe: directed vectors, latency, stall, reset and random traffic.
// Expected results come from a plain-arithmetic model and an in-order scoreboard.
// out_ready is randomly throttled during the random phase.
module tb_fsub_pipe;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] x1, x2, y;
   logic        in_valid, in_ready, out_valid, out_ready;
`ifdef FSUB_FLAGS_EN
   logic [1:0]  exc;
`endif

   always #5 clk = ~clk;

   fsub_pipe dut (
      .clk(clk), .rst(rst), .x1(x1), .x2(x2),
      .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FSUB_FLAGS_EN
      , .exc(exc)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;
   logic [33:0] exp_q[$];
   logic        held_vld = 1'b0;
   logic [31:0] held_y   = 32'h0;
   int          seen_out = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Reference: {overflow, underflow, y} from value-level arithmetic.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
      logic   sa, sb, ss;
      int     ea, eb, es, ei, d, msb, e;
      longint ma, mb, ms, mi, r, mant;
      sa = a[31]; sb = ~b[31];
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      ma = longint'({1'b1, a[22:0]}); mb = longint'({1'b1, b[22:0]});
      if (ea == 0) return {2'b00, sb, b[30:0]};
      if (eb == 0) return {2'b00, a};
      if (ea > eb || (ea == eb && ma >= mb)) begin
         es = ea; ms = ma; ss = sa; ei = eb; mi = mb;
      end else begin
         es = eb; ms = mb; ss = sb; ei = ea; mi = ma;
      end
      d = es - ei;
      if (d > 31) d = 31;
      if (sa == sb) r = ms * 4 + ((mi * 4) >> d);
      else          r = ms * 4 - ((mi * 4) >> d);
      if (r == 0) return {2'b00, sa & sb, 31'h0};
      msb = 0;
      for (int k = 0; k < 40; k++) if (((r >> k) & 1) == 1) msb = k;
      e = es + msb - 25;
      if (e >= 255) return {2'b10, ss, 8'hFF, 23'h0};
      if (e <= 0)   return {2'b01, ss, 31'h0};
      if (msb >= 23) mant = r >> (msb - 23);
      else           mant = r << (23 - msb);
      return {2'b00, ss, 8'(e), 23'(mant)};
   endfunction

   function automatic logic [31:0] rnd_fp(input logic [31:0] ref_x);
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0: v[30:23] = 8'h00;
         1: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'hFE;
         2: v[30:23] = 8'($urandom_range(1, 3));
         3: v[30:0]  = ref_x[30:0];
         4: v[30:23] = ref_x[30:23] + 8'($urandom_range(0, 2));
         default: v[30:23] = 8'($urandom_range(110, 150));
      endcase
      return v;
   endfunction

   // Output side: in-order scoreboard plus hold-while-stalled check.
   always @(negedge clk) begin
      logic [33:0] e;
      if (held_vld && out_valid) chk("stall_hold", y, held_y);
      if (out_valid && out_ready) begin
         seen_out++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_out: got result %h, expected no output", y);
         end else begin
            e = exp_q.pop_front();
            chk("y", y, e[31:0]);
`ifdef FSUB_FLAGS_EN
            chk("exc", 32'(exc), 32'(e[33:32]));
`endif
         end
      end
      held_vld = out_valid && !out_ready;
      held_y   = y;
   end

   // Present one operand pair and hold it until accepted (bounded).
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [33:0] e);
      int n;
      bit done;
      n = 0; done = 1'b0;
      x1 = a; x2 = b; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end else if (n > 60) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready %0b, expected 1", in_ready);
            done = 1'b1;
         end
         n++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); n++;
      end
      #1;
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic [1:0]  f;
   } vec_t;

   vec_t tbl[9];
   bit   rnd_done;

   initial begin
      tbl[0] = '{32'h40400000, 32'h3F800000, 32'h40000000, 2'b00};
      tbl[1] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 2'b00};
      tbl[2] = '{32'hBF800000, 32'hBF800000, 32'h00000000, 2'b00};
      tbl[3] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 2'b00};
      tbl[4] = '{32'h40000000, 32'h00000000, 32'h40000000, 2'b00};
      tbl[5] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2'b10};
      tbl[6] = '{32'h00800000, 32'h00C00000, 32'h80000000, 2'b01};
      tbl[7] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 2'b00};
      tbl[8] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 2'b00};

      rst = 1'b1; in_valid = 1'b0; x1 = 32'h0; x2 = 32'h0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", y, 32'h0);
`ifdef FSUB_FLAGS_EN
      chk("rst_exc", 32'(exc), 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;

      // Latency: out_valid exactly three cycles after the transfer.
      begin
         int n;
         send(tbl[0].a, tbl[0].b, {tbl[0].f, tbl[0].y});
         n = 0;
         do begin
            @(negedge clk); n++;
         end while (!out_valid && n < 10);
         chk("latency", 32'(n), 32'd3);
      end
      drain();

      // Directed vectors, back to back.
      for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, {tbl[i].f, tbl[i].y});
      drain();

      // Backpressure: five pairs while the consumer stalls for six cycles.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               logic [31:0] a, b;
               a = 32'h40400000 + 32'(i << 20);
               b = 32'h3F800000 + 32'(i << 19);
               send(a, b, model(a, b));
            end
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three results in flight: none may ever appear.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h41000000, 32'(32'h3F800000 + i), 34'h0);
      rst = 1'b1;
      exp_q.delete();
      out_ready = 1'b1;
      seen_out = 0;
      @(negedge clk);
      chk("rst_cycle_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_y", y, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      chk("flushed_results_seen", 32'(seen_out), 32'd0);

      // Random traffic with random output throttling.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               logic [31:0] a, b;
               a = rnd_fp(32'h3F800000);
               b = rnd_fp(a);
               if ($urandom_range(0, 1) == 1) begin
                  logic [31:0] t;
                  t = a; a = b; b = t;
               end
               repeat ($urandom_range(0, 1)) begin
                  @(posedge clk); #1;
               end
               send(a, b, model(a, b));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
